// File: rtl/ram_prog_loader.sv
// Bus-master sequencer for the DFF RAM: LOAD streams a valid/ready source into
// consecutive addresses, DUMP reads every address back out to a valid/ready sink.
//
// state      | meaning
// S_IDLE     | waiting for start_load / start_dump
// S_LOAD     | accepting bytes, one RAM write per handshake
// S_RD_REQ   | ce_n low for one cycle at mar = addr
// S_RD_CAP   | RAM data_out valid, captured into out_data
// S_DUMP_OUT | holding out_data/out_valid until out_ready
// S_DONE     | one-cycle done pulse
module ram_prog_loader #(
  parameter int RAM_BYTES = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_load,
  input  logic                 start_dump,
  input  logic                 abort,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] mar,
  output logic [7:0]           ram_din,
  output logic                 lr_n,
  output logic                 ce_n,
  input  logic [7:0]           ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RD_REQ, S_RD_CAP, S_DUMP_OUT, S_DONE
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(RAM_BYTES - 1);

  state_t               state;
  logic [ADDR_BITS-1:0] addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_load) begin
            addr  <= '0;
            state <= S_LOAD;
          end else if (start_dump) begin
            addr  <= '0;
            state <= S_RD_REQ;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (addr == LAST) state <= S_DONE;
            else              addr  <= addr + 1'b1;
          end
        end
        S_RD_REQ: state <= S_RD_CAP;
        S_RD_CAP: begin
          out_data  <= ram_dout;
          out_valid <= 1'b1;
          state     <= S_DUMP_OUT;
        end
        S_DUMP_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // address saturates on the last byte so it never wraps onto mar
            if (addr == LAST) begin
              state <= S_DONE;
            end else begin
              addr  <= addr + 1'b1;
              state <= S_RD_REQ;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // abort suppresses the same-cycle write and handshake
  assign in_ready = (state == S_LOAD) && !abort;
  assign lr_n     = !(in_ready && in_valid);
  assign ce_n     = (state != S_RD_REQ);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign mar      = addr;
  assign ram_din  = in_data;

endmodule

// File: doc/ram_prog_loader.md
# ram_prog_loader

Bus-master sequencer for the 16-byte DFF RAM. It owns the RAM's `mar`, `data_in`, `lr_n` and `ce_n` pins and consumes its registered `data_out`. It has two modes, each moving one whole image: LOAD streams bytes from a valid/ready source into consecutive RAM addresses, and DUMP reads every address back out through a valid/ready sink. It sits between the external programming interface and the RAM.

## Interface
Parameters:
- `RAM_BYTES`, default 16: number of bytes transferred per LOAD/DUMP. Must be ≤ 2^`ADDR_BITS`.
- `ADDR_BITS`, default 4: width of `mar`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_load` in 1: begin LOAD. Sampled only in IDLE.
- `start_dump` in 1: begin DUMP. Sampled only in IDLE.
- `abort` in 1: return to IDLE from any state.
- `in_data` in 8: LOAD byte.
- `in_valid` in 1: source has a byte.
- `in_ready` out 1: block accepts a byte.
- `out_data` out 8: DUMP byte, registered.
- `out_valid` out 1: DUMP byte available.
- `out_ready` in 1: sink accepts the byte.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse on completion of LOAD or DUMP.
- `mar` out ADDR_BITS: RAM address, equal to the internal address register.
- `ram_din` out 8: RAM write data, equal to `in_data` (combinational pass-through).
- `lr_n` out 1: RAM write strobe, active-low.
- `ce_n` out 1: RAM read enable, active-low.
- `ram_dout` in 8: RAM registered read data.

## Operation
States:
- **IDLE**
  - `start_load` → LOAD.
  - Else `start_dump` → RD_REQ.
  - Either transition clears the address register to 0.
  - If both starts are asserted in the same cycle, `start_load` wins.
- **LOAD**
  - `in_ready`=1.
  - `lr_n` = !`in_valid` (combinational). A write and the handshake occur on the same edge.
  - On handshake: if addr = `RAM_BYTES`-1 → DONE; else addr+1.
  - Throughput: 1 byte/cycle.
- **RD_REQ**: `ce_n`=0 for exactly one cycle, `mar`=addr → RD_CAP.
- **RD_CAP**
  - `ram_dout` is valid during this state.
  - At the edge: `out_data`←`ram_dout`, `out_valid`←1 → DUMP_OUT.
- **DUMP_OUT**
  - Hold `out_data` and `out_valid` until `out_ready`.
  - On handshake: `out_valid`←0. If addr = `RAM_BYTES`-1 → DONE; else addr+1 → RD_REQ.
- **DONE**: `done`=1 for one cycle → IDLE.

Rules in every state:
- `lr_n`=1 outside LOAD.
- `ce_n`=1 outside RD_REQ.
- `lr_n` and `ce_n` are never low together.
- The address register saturates by termination and never wraps. The address after the last byte is never driven onto `mar`.

`abort` (highest priority, any state):
- Next state is IDLE and `out_valid`←0.
- No `done` pulse.
- In LOAD, `abort` forces `lr_n`=1 and `in_ready`=0 in that same cycle, so no write occurs and no byte is accepted.
- RAM contents already written stay as written.

Any start asserted while `busy` is ignored.

## Timing
Reset values (asynchronous, applied immediately on `rst_n` low):
- state IDLE, address 0, so `mar`=0.
- `lr_n`=1, `ce_n`=1.
- `in_ready`=0, `out_valid`=0, `out_data`=0x00.
- `busy`=0, `done`=0.

Reset mid-operation aborts identically to `abort`, with all values above restored.

Latency:
- Start at edge k: first LOAD write can occur at edge k+1.
- A DUMP begun at edge k asserts `ce_n` during cycle k+1 and `out_valid` from cycle k+3 (after edge k+2).
- DUMP costs 3 cycles per byte with `out_ready` held high.
- `done` asserts the cycle after the final handshake. `busy` falls the cycle after `done`.

Back-to-back operation: a new start is accepted in the first IDLE cycle after DONE.

## Test plan
- **Reset:** drive activity, then pulse `rst_n` low mid-LOAD → all outputs equal reset values asynchronously, before the next edge, and `lr_n`=1 immediately.
- **Streaming LOAD:** `start_load`, then `in_valid` held with bytes 0xA0..0xAF → `lr_n` low 16 consecutive cycles, `mar` 0..15, `done` 1 cycle after the 16th byte, RAM[i]=0xA0+i.
- **DUMP, no backpressure:** after the LOAD above, `start_dump` with `out_ready`=1 → `out_data` 0xA0..0xAF in order, one per 3 cycles, `ce_n` low exactly 16 single cycles, `done` after 0xAF.
- **Backpressure:**
  - During DUMP, hold `out_ready`=0 for 5 cycles at byte 3 → `out_data`=0xA3 is stable with `out_valid`=1 and no `ce_n` activity.
  - During LOAD, insert `in_valid` gaps → `lr_n` high in every gap and `mar` unchanged.
- **Abort:** assert `abort` in the same cycle as the 6th LOAD byte (0x55) → no write (RAM[5] retains its old value), IDLE next cycle, no `done`. The following `start_load` begins again at `mar`=0.
- **Start arbitration:** `start_load`=`start_dump`=1 in IDLE → LOAD is entered. Starts asserted while `busy` cause no state change.
